// File: rtl/timing_sequencer_pkg.sv
// timing_sequencer_pkg
// Shared definitions for the timing/decode stage: run-state encoding,
// opcode indices into the D vector, default last-T-step constants and
// instruction-register field positions.
package timing_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam int D_AND = 0;
   localparam int D_ADD = 1;
   localparam int D_LDA = 2;
   localparam int D_STA = 3;
   localparam int D_BUN = 4;
   localparam int D_BSA = 5;
   localparam int D_ISZ = 6;
   localparam int D_REG = 7;

   localparam int LAST_REG_DEF = 6;
   localparam int LAST_STA_DEF = 8;
   localparam int LAST_MEM_DEF = 10;

   localparam int IR_I     = 15;
   localparam int IR_OP_HI = 14;
   localparam int IR_OP_LO = 12;
   localparam int IR_HLT   = 0;

endpackage

// File: rtl/timing_sequencer_onehot_decoder.sv
// onehot_decoder
// N-to-2**N one-hot decoder with enable; output is all zeros when disabled.
// Ports:
//   sel    in  N       binary index
//   en     in  1       enable
//   onehot out 2**N    one-hot result
module onehot_decoder #(
   parameter int N = 4
) (
   input  logic [N-1:0]      sel,
   input  logic              en,
   output logic [2**N-1:0]   onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/timing_sequencer.sv
// timing_sequencer
// Sequence counter, start/run/halt state machine, T and D one-hot vectors,
// per-class end-step selection and HLT detection for the basic computer.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds input step; every
// non-halting instruction returns to IDLE so one instruction runs per launch).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle launch from IDLE/HALT
//   step            (SEQ_SINGLE_STEP_EN only) launch from IDLE
//   stop            level request: go IDLE at next instruction boundary
//   ir[15:0]        instruction register (I, opcode, HLT bit)
//   t_onehot        timing vector T0..T(2**SC_W-1), zero unless running
//   d_onehot        latched opcode decode D0..D7
//   sc              sequence count
//   running/halted  state flags
//   instr_done      pulse on last T step of each instruction
//   seq_err         sticky: sequence counter overran without an end step
//
// state | meaning
// IDLE  | stopped, waiting for start (or step)
// RUN   | sequencing T steps
// HALT  | stopped by HLT, waiting for start
module timing_sequencer
   import timing_sequencer_pkg::*;
#(
   parameter int SC_W     = 4,
   parameter int LAST_REG = LAST_REG_DEF,
   parameter int LAST_STA = LAST_STA_DEF,
   parameter int LAST_MEM = LAST_MEM_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                 step,
`endif
   input  logic                 stop,
   input  logic [15:0]          ir,
   output logic [2**SC_W-1:0]   t_onehot,
   output logic [7:0]           d_onehot,
   output logic [SC_W-1:0]      sc,
   output logic                 running,
   output logic                 halted,
   output logic                 instr_done,
   output logic                 seq_err
);

   localparam logic [SC_W-1:0] SC_MAX      = {SC_W{1'b1}};
   localparam logic [SC_W-1:0] LAST_REG_SC = SC_W'(LAST_REG);
   localparam logic [SC_W-1:0] LAST_STA_SC = SC_W'(LAST_STA);
   localparam logic [SC_W-1:0] LAST_MEM_SC = SC_W'(LAST_MEM);

   state_t           state_q, state_d;
   logic [SC_W-1:0]  sc_q;
   logic [2:0]       op_q;
   logic             d_valid_q;
   logic             i_q;
   logic             seq_err_q;

   logic             run_now;
   logic [SC_W-1:0]  last_step;
   logic             end_step;
   logic             hlt_hit;
   logic             guard_hit;
   logic             launch_idle;
   logic             single_step;

   logic             unused_ir_bits;
   assign unused_ir_bits = ^ir[11:1];

`ifdef SEQ_SINGLE_STEP_EN
   assign launch_idle = start | step;
   assign single_step = 1'b1;
`else
   assign launch_idle = start;
   assign single_step = 1'b0;
`endif

   assign run_now = (state_q == RUN);

   // Class select uses the latched decode; D7 covers both register-ref and I/O.
   always_comb begin
      if (d_onehot[D_REG])      last_step = LAST_REG_SC;
      else if (d_onehot[D_STA]) last_step = LAST_STA_SC;
      else                      last_step = LAST_MEM_SC;
   end

   assign end_step  = run_now && (sc_q == last_step);
   assign hlt_hit   = end_step && d_onehot[D_REG] && !i_q && ir[IR_HLT];
   assign guard_hit = run_now && !end_step && (sc_q == SC_MAX);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (launch_idle) state_d = RUN;
         HALT: if (start)       state_d = RUN;
         RUN: begin
            if (hlt_hit)                              state_d = HALT;
            else if (end_step && (stop || single_step)) state_d = IDLE;
            else if (guard_hit)                       state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      running    = run_now;
      halted     = (state_q == HALT);
      instr_done = end_step;
      seq_err    = seq_err_q;
      sc         = sc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sc_q      <= '0;
         op_q      <= '0;
         d_valid_q <= 1'b0;
         i_q       <= 1'b0;
         seq_err_q <= 1'b0;
      end else begin
         if (run_now && !end_step && !guard_hit) sc_q <= sc_q + 1'b1;
         else                                    sc_q <= '0;

         // IR is settled by the end of T2, so capture on the T3 edge.
         if (run_now && sc_q == SC_W'(3)) begin
            op_q      <= ir[IR_OP_HI:IR_OP_LO];
            i_q       <= ir[IR_I];
            d_valid_q <= 1'b1;
         end
         if (run_now && state_d != RUN) d_valid_q <= 1'b0;

         if (guard_hit) seq_err_q <= 1'b1;
      end
   end

   onehot_decoder #(.N(SC_W)) u_t_dec (
      .sel    (sc_q),
      .en     (run_now),
      .onehot (t_onehot)
   );

   onehot_decoder #(.N(3)) u_d_dec (
      .sel    (op_q),
      .en     (d_valid_q),
      .onehot (d_onehot)
   );

endmodule
